// File: rtl/sprite_overlay_ctrl.sv
// sprite_overlay_ctrl: sprite ROM addressing and transparent overlay with frame-synchronous
// position update, integer scaling, blinking and a ROM-latency-aligned registered output.
module sprite_overlay_ctrl #(
   parameter int          X0           = 265,
   parameter int          Y0           = 277,
   parameter int          W            = 96,
   parameter int          H            = 11,
   parameter int          ROW_W        = 4,
   parameter int          COL_W        = 7,
   parameter int          SCALE_SH     = 0,
   parameter int          ROM_LAT      = 1,
   parameter logic [11:0] TRANSP       = 12'hFFF,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bright,
   input  logic             en,
   input  logic [9:0]       hCount,
   input  logic [9:0]       vCount,
   input  logic [11:0]      background,
   input  logic [9:0]       pos_x,
   input  logic [9:0]       pos_y,
   input  logic             pos_load,
   input  logic             blink_en,
   output logic [ROW_W-1:0] rom_row,
   output logic [COL_W-1:0] rom_col,
   input  logic [11:0]      rom_color,
   output logic [11:0]      rgb,
   output logic             sprite_px
);
   localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [10:0] WS = 11'(W << SCALE_SH);
   localparam logic [10:0] HS = 11'(H << SCALE_SH);
   typedef enum logic {VISIBLE, HIDDEN} blink_t;
   blink_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [9:0] sx, sy, ax, ay, dx, dy;
   logic frame_tick, on, hit;
   logic [ROM_LAT-1:0] on_d, br_d;
   logic [11:0] bg_d [ROM_LAT];
   assign frame_tick = hCount == 10'd0 && vCount == 10'd0;
   // Staged position only becomes active at a frame boundary, so a frame never tears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx <= 10'(X0);
         sy <= 10'(Y0);
         ax <= 10'(X0);
         ay <= 10'(Y0);
      end else begin
         if (pos_load) begin
            sx <= pos_x;
            sy <= pos_y;
         end
         if (frame_tick) begin
            ax <= pos_load ? pos_x : sx;
            ay <= pos_load ? pos_y : sy;
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= VISIBLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (!blink_en) begin
         state_nx = VISIBLE;
         cnt_nx   = '0;
      end else if (frame_tick) begin
         cnt_nx   = cnt == CW'(BLINK_FRAMES - 1) ? '0 : cnt + 1'b1;
         state_nx = cnt == CW'(BLINK_FRAMES - 1) ? (state == VISIBLE ? HIDDEN : VISIBLE) : state;
      end
   end
   // Upper bounds at 11 bits so a window running past 1023 does not wrap around.
   assign dx = hCount - ax;
   assign dy = vCount - ay;
   assign on = en && state == VISIBLE &&
               hCount >= ax && {1'b0, hCount} < {1'b0, ax} + WS &&
               vCount >= ay && {1'b0, vCount} < {1'b0, ay} + HS;
   assign rom_row = ROW_W'(dy >> SCALE_SH);
   assign rom_col = COL_W'(dx >> SCALE_SH);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         on_d <= '0;
         br_d <= '0;
         for (int i = 0; i < ROM_LAT; i++) bg_d[i] <= '0;
      end else begin
         on_d    <= ROM_LAT'({on_d, on});
         br_d    <= ROM_LAT'({br_d, bright});
         bg_d[0] <= background;
         for (int i = 1; i < ROM_LAT; i++) bg_d[i] <= bg_d[i-1];
      end
   end
   assign hit = br_d[ROM_LAT-1] && on_d[ROM_LAT-1] && rom_color != TRANSP;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb       <= '0;
         sprite_px <= 1'b0;
      end else begin
         rgb       <= !br_d[ROM_LAT-1] ? 12'h000 : hit ? rom_color : bg_d[ROM_LAT-1];
         sprite_px <= hit;
      end
   end
endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// tb_sprite_overlay_ctrl: directed checks of two configurations (unscaled, latency 1; and
// scale 2x, ROM latency 3) driven from shared stimulus, each with its own ROM model.
module tb_sprite_overlay_ctrl;
   localparam logic [11:0] BG = 12'h5A5;
   logic clk = 1'b0;
   logic rst, bright, en, pos_load, blink_en;
   logic [9:0] hCount, vCount, pos_x, pos_y;
   logic [11:0] background;
   logic [3:0] rom_row_a, rom_row_b;
   logic [6:0] rom_col_a, rom_col_b;
   logic [11:0] rom_color_a, rom_color_b, rgb_a, rgb_b;
   logic spr_a, spr_b;
   logic [11:0] ra;
   logic [11:0] rb [3];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   sprite_overlay_ctrl #(.BLINK_FRAMES(2)) dut_a (
      .clk(clk), .rst(rst), .bright(bright), .en(en), .hCount(hCount), .vCount(vCount),
      .background(background), .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load),
      .blink_en(blink_en), .rom_row(rom_row_a), .rom_col(rom_col_a),
      .rom_color(rom_color_a), .rgb(rgb_a), .sprite_px(spr_a));
   sprite_overlay_ctrl #(.BLINK_FRAMES(2), .SCALE_SH(1), .ROM_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .bright(bright), .en(en), .hCount(hCount), .vCount(vCount),
      .background(background), .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load),
      .blink_en(blink_en), .rom_row(rom_row_b), .rom_col(rom_col_b),
      .rom_color(rom_color_b), .rgb(rgb_b), .sprite_px(spr_b));
   // ROM image: column 5 is transparent, otherwise {row, 0, col}.
   function automatic logic [11:0] romf(input logic [3:0] r, input logic [6:0] c);
      return c == 7'd5 ? 12'hFFF : {r, 1'b0, c};
   endfunction
   always @(posedge clk) begin
      ra    <= romf(rom_row_a, rom_col_a);
      rb[0] <= romf(rom_row_b, rom_col_b);
      rb[1] <= rb[0];
      rb[2] <= rb[1];
   end
   assign rom_color_a = ra;
   assign rom_color_b = rb[2];
   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic look(input logic [9:0] h, input logic [9:0] v);
      hCount = h;
      vCount = v;
      repeat (6) tick();
   endtask
   task automatic both(input string tag, input logic [11:0] ea, input logic sa,
                       input logic [11:0] eb, input logic sb);
      chk({tag, "_rgb_a"}, rgb_a, ea);
      chk({tag, "_spr_a"}, {11'd0, spr_a}, {11'd0, sa});
      chk({tag, "_rgb_b"}, rgb_b, eb);
      chk({tag, "_spr_b"}, {11'd0, spr_b}, {11'd0, sb});
   endtask
   task automatic frame();
      hCount = 10'd0;
      vCount = 10'd0;
      tick();
   endtask
   initial begin
      rst = 1'b0; bright = 1'b1; en = 1'b1; background = BG;
      hCount = 10'd500; vCount = 10'd500;
      pos_x = '0; pos_y = '0; pos_load = 1'b0; blink_en = 1'b0;
      tick(); tick();
      both("reset", 12'h000, 1'b0, 12'h000, 1'b0);
      rst = 1'b1;
      look(264, 277);
      both("left_out", BG, 1'b0, BG, 1'b0);
      hCount = 10'd265;
      tick();
      chk("row_a_x0", {8'd0, rom_row_a}, 12'd0);
      chk("col_a_x0", {5'd0, rom_col_a}, 12'd0);
      chk("lat1_a", rgb_a, BG);
      tick();
      chk("lat2_a", rgb_a, 12'h000);
      chk("lat2_spr_a", {11'd0, spr_a}, 12'd1);
      tick();
      chk("lat3_b", rgb_b, BG);
      tick();
      chk("lat4_b", rgb_b, 12'h000);
      chk("lat4_spr_b", {11'd0, spr_b}, 12'd1);
      look(300, 277);
      both("col35", 12'h023, 1'b1, 12'h011, 1'b1);
      look(300, 280);
      both("row3", 12'h323, 1'b1, 12'h111, 1'b1);
      hCount = 10'd268; vCount = 10'd282;
      #1;
      chk("col_b_scaled", {5'd0, rom_col_b}, 12'd1);
      chk("row_b_scaled", {8'd0, rom_row_b}, 12'd2);
      repeat (6) tick();
      both("scaled", 12'h503, 1'b1, 12'h201, 1'b1);
      look(270, 277);
      both("transp", BG, 1'b0, 12'h002, 1'b1);
      look(360, 277);
      both("right_in_a", 12'h05F, 1'b1, 12'h02F, 1'b1);
      look(361, 277);
      both("right_out_a", BG, 1'b0, 12'h030, 1'b1);
      look(456, 277);
      both("right_in_b", BG, 1'b0, 12'h05F, 1'b1);
      look(457, 277);
      both("right_out_b", BG, 1'b0, BG, 1'b0);
      look(300, 287);
      both("bottom_in_a", 12'hA23, 1'b1, 12'h511, 1'b1);
      look(300, 288);
      both("bottom_out_a", BG, 1'b0, 12'h511, 1'b1);
      look(300, 298);
      both("bottom_in_b", BG, 1'b0, 12'hA11, 1'b1);
      look(300, 299);
      both("bottom_out_b", BG, 1'b0, BG, 1'b0);
      bright = 1'b0;
      look(300, 277);
      both("blank", 12'h000, 1'b0, 12'h000, 1'b0);
      bright = 1'b1;
      en = 1'b0;
      look(300, 277);
      both("disabled", BG, 1'b0, BG, 1'b0);
      en = 1'b1;
      pos_x = 10'd100; pos_y = 10'd50;
      hCount = 10'd10; vCount = 10'd300; pos_load = 1'b1;
      tick();
      pos_load = 1'b0;
      look(300, 277);
      both("no_tear_old", 12'h023, 1'b1, 12'h011, 1'b1);
      look(100, 50);
      both("no_tear_new", BG, 1'b0, BG, 1'b0);
      frame();
      look(100, 50);
      chk("row_a_moved", {8'd0, rom_row_a}, 12'd0);
      chk("col_a_moved", {5'd0, rom_col_a}, 12'd0);
      both("moved_new", 12'h000, 1'b1, 12'h000, 1'b1);
      look(300, 277);
      both("moved_old", BG, 1'b0, BG, 1'b0);
      pos_x = 10'd10; pos_y = 10'd10;
      hCount = 10'd0; vCount = 10'd0; pos_load = 1'b1;
      tick();
      pos_load = 1'b0;
      look(10, 10);
      both("coinc_new", 12'h000, 1'b1, 12'h000, 1'b1);
      look(100, 50);
      both("coinc_old", BG, 1'b0, BG, 1'b0);
      blink_en = 1'b1;
      look(12, 10);
      both("blink_f0", 12'h002, 1'b1, 12'h001, 1'b1);
      frame(); look(12, 10);
      both("blink_f1", 12'h002, 1'b1, 12'h001, 1'b1);
      frame(); look(12, 10);
      both("blink_f2", BG, 1'b0, BG, 1'b0);
      frame(); look(12, 10);
      both("blink_f3", BG, 1'b0, BG, 1'b0);
      frame(); look(12, 10);
      both("blink_f4", 12'h002, 1'b1, 12'h001, 1'b1);
      frame(); look(12, 10);
      both("blink_f5", 12'h002, 1'b1, 12'h001, 1'b1);
      frame(); look(12, 10);
      both("blink_f6", BG, 1'b0, BG, 1'b0);
      frame(); look(12, 10);
      both("blink_f7", BG, 1'b0, BG, 1'b0);
      blink_en = 1'b0;
      look(12, 10);
      both("blink_off", 12'h002, 1'b1, 12'h001, 1'b1);
      blink_en = 1'b1;
      frame(); look(12, 10);
      both("blink_cnt0", 12'h002, 1'b1, 12'h001, 1'b1);
      frame(); look(12, 10);
      both("blink_rehide", BG, 1'b0, BG, 1'b0);
      blink_en = 1'b0;
      look(12, 10);
      both("pre_reset", 12'h002, 1'b1, 12'h001, 1'b1);
      #2 rst = 1'b0;
      #1;
      both("async_reset", 12'h000, 1'b0, 12'h000, 1'b0);
      tick();
      rst = 1'b1;
      look(300, 277);
      both("post_reset_def", 12'h023, 1'b1, 12'h011, 1'b1);
      look(12, 10);
      both("post_reset_old", BG, 1'b0, BG, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
